// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings, FSM state type and the misalignment predicate for the
// MEM-stage data-memory access unit (mem_access_stage / mem_align).
package mem_pkg;

  // load_con encodings
  localparam logic [2:0] LoadLb  = 3'b000;
  localparam logic [2:0] LoadLh  = 3'b001;
  localparam logic [2:0] LoadLw  = 3'b010;
  localparam logic [2:0] LoadLbu = 3'b100;
  localparam logic [2:0] LoadLhu = 3'b101;

  // store_con encodings
  localparam logic [1:0] StoreNone = 2'b00;
  localparam logic [1:0] StoreSb   = 2'b01;
  localparam logic [1:0] StoreSh   = 2'b10;
  localparam logic [1:0] StoreSw   = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } state_e;

  // Stores take priority over loads, so the store type decides alignment whenever one is present.
  function automatic logic is_misaligned(input logic [1:0] store_con,
                                         input logic [2:0] load_con,
                                         input logic [1:0] k);
    logic r;
    r = 1'b0;
    if (store_con != StoreNone) begin
      if (store_con == StoreSh)      r = k[0];
      else if (store_con == StoreSw) r = (k != 2'b00);
    end else begin
      if ((load_con == LoadLh) || (load_con == LoadLhu)) r = k[0];
      else if (load_con == LoadLw)                        r = (k != 2'b00);
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: combinational byte-lane logic for the MEM stage.
//   Store path: store_con_i/k_i/wdata_i -> replicated lane data wdata_o and byte strobes wstrb_o.
//   Load path:  load_con_i/rk_i/rdata_i -> shifted, sign/zero-extended load_data_o.
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  store_con_i,
  input  logic [1:0]  k_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  input  logic [2:0]  load_con_i,
  input  logic [1:0]  rk_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] load_data_o
);

  logic [31:0] w_shifted;

  // Replicating the byte/half across the word puts it on every lane; strobes pick the real one.
  always_comb begin
    wdata_o = '0;
    wstrb_o = '0;
    unique case (store_con_i)
      StoreSb: begin
        wdata_o = {4{wdata_i[7:0]}};
        wstrb_o = 4'b0001 << k_i;
      end
      StoreSh: begin
        wdata_o = {2{wdata_i[15:0]}};
        wstrb_o = 4'b0011 << k_i;
      end
      StoreSw: begin
        wdata_o = wdata_i;
        wstrb_o = 4'b1111;
      end
      default: begin
        wdata_o = '0;
        wstrb_o = '0;
      end
    endcase
  end

  assign w_shifted = rdata_i >> {rk_i, 3'b000};

  always_comb begin
    load_data_o = w_shifted;
    case (load_con_i)
      LoadLb:  load_data_o = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LoadLh:  load_data_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LoadLbu: load_data_o = {24'h000000, w_shifted[7:0]};
      LoadLhu: load_data_o = {16'h0000, w_shifted[15:0]};
      default: load_data_o = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage data-memory access unit behind the EX/MEM register.
//   Inputs from EX/MEM: mem_read_i, load_con_i, store_con_i, addr_i, wdata_i; stall_i holds DONE.
//   Bus side: dm_req_o/dm_we_o/dm_addr_o/dm_wstrb_o/dm_wdata_o (registered, stable in REQ),
//             dm_gnt_i, dm_rvalid_i, dm_rdata_i.
//   Results: load_data_o (registered), mem_stall_o, misalign_o (pulse while IDLE sees a bad access).
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_i,
  input  logic [2:0]        load_con_i,
  input  logic [1:0]        store_con_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              stall_i,
  output logic              dm_req_o,
  output logic              dm_we_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [3:0]        dm_wstrb_o,
  output logic [DATA_W-1:0] dm_wdata_o,
  input  logic              dm_gnt_i,
  input  logic              dm_rvalid_i,
  input  logic [DATA_W-1:0] dm_rdata_i,
  output logic [DATA_W-1:0] load_data_o,
  output logic              mem_stall_o,
  output logic              misalign_o
);

  state_e            r_state;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_wstrb;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_load_data;
  logic [1:0]        r_k;
  logic [2:0]        r_load_con;
  logic              r_is_load;

  logic              w_is_store;
  logic              w_access;
  logic              w_misalign;
  logic [31:0]       w_wdata;
  logic [3:0]        w_wstrb;
  logic [31:0]       w_load_ext;

  assign w_is_store = (store_con_i != StoreNone);
  assign w_access   = mem_read_i | w_is_store;
  assign w_misalign = w_access & is_misaligned(store_con_i, load_con_i, addr_i[1:0]);

  // Load extraction uses the offset/type latched at issue, so the result does not depend on
  // EX/MEM still holding the same address when the response arrives.
  mem_align u_mem_align (
    .store_con_i (store_con_i),
    .k_i         (addr_i[1:0]),
    .wdata_i     (wdata_i),
    .wdata_o     (w_wdata),
    .wstrb_o     (w_wstrb),
    .load_con_i  (r_load_con),
    .rk_i        (r_k),
    .rdata_i     (dm_rdata_i),
    .load_data_o (w_load_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wstrb     <= '0;
      r_wdata     <= '0;
      r_load_data <= '0;
      r_k         <= '0;
      r_load_con  <= '0;
      r_is_load   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_access) begin
            if (w_misalign) begin
              r_state     <= StDone;
              r_load_data <= '0;
            end else begin
              r_state    <= StReq;
              r_req      <= 1'b1;
              r_we       <= w_is_store;
              r_addr     <= {addr_i[ADDR_W-1:2], 2'b00};
              r_wstrb    <= w_wstrb;
              r_wdata    <= w_wdata;
              r_k        <= addr_i[1:0];
              r_load_con <= load_con_i;
              r_is_load  <= ~w_is_store;
            end
          end
        end
        StReq: begin
          if (dm_gnt_i) begin
            r_req   <= 1'b0;
            r_state <= StWait;
          end
        end
        StWait: begin
          if (dm_rvalid_i) begin
            r_state <= StDone;
            if (r_is_load) r_load_data <= w_load_ext;
          end
        end
        StDone: begin
          // EX/MEM advances on this edge; the stage is idle again next cycle.
          if (!stall_i) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign dm_req_o    = r_req;
  assign dm_we_o     = r_we;
  assign dm_addr_o   = r_addr;
  assign dm_wstrb_o  = r_wstrb;
  assign dm_wdata_o  = r_wdata;
  assign load_data_o = r_load_data;

  assign mem_stall_o = ((r_state == StIdle) & w_access) | (r_state == StReq) | (r_state == StWait);
  assign misalign_o  = (r_state == StIdle) & w_misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_i;
  logic [2:0]  load_con_i;
  logic [1:0]  store_con_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_i;
  logic        dm_req_o;
  logic        dm_we_o;
  logic [31:0] dm_addr_o;
  logic [3:0]  dm_wstrb_o;
  logic [31:0] dm_wdata_o;
  logic        dm_gnt_i;
  logic        dm_rvalid_i;
  logic [31:0] dm_rdata_i;
  logic [31:0] load_data_o;
  logic        mem_stall_o;
  logic        misalign_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_stage #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read_i  (mem_read_i),
    .load_con_i  (load_con_i),
    .store_con_i (store_con_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .stall_i     (stall_i),
    .dm_req_o    (dm_req_o),
    .dm_we_o     (dm_we_o),
    .dm_addr_o   (dm_addr_o),
    .dm_wstrb_o  (dm_wstrb_o),
    .dm_wdata_o  (dm_wdata_o),
    .dm_gnt_i    (dm_gnt_i),
    .dm_rvalid_i (dm_rvalid_i),
    .dm_rdata_i  (dm_rdata_i),
    .load_data_o (load_data_o),
    .mem_stall_o (mem_stall_o),
    .misalign_o  (misalign_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic [2:0] lc, input logic [1:0] sc,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_read_i  = rd;
    load_con_i  = lc;
    store_con_i = sc;
    addr_i      = a;
    wdata_i     = wd;
  endtask

  // Full aligned access; returns with the DUT in DONE and the access still presented.
  task automatic run_txn(input string tag, input logic rd, input logic [2:0] lc,
                         input logic [1:0] sc, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rword, input int gnt_wait,
                         input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_strb,
                         input logic [31:0] e_wdata);
    step();
    drive(rd, lc, sc, a, wd);
    #1;
    check_eq({tag, "_c0_stall"}, 32'(mem_stall_o), 32'd1);
    check_eq({tag, "_c0_misalign"}, 32'(misalign_o), 32'd0);
    step();
    for (int i = 0; i <= gnt_wait; i++) begin
      check_eq({tag, "_req"}, 32'(dm_req_o), 32'd1);
      check_eq({tag, "_addr"}, dm_addr_o, e_addr);
      check_eq({tag, "_we"}, 32'(dm_we_o), 32'(e_we));
      check_eq({tag, "_wstrb"}, 32'(dm_wstrb_o), 32'(e_strb));
      check_eq({tag, "_wdata"}, dm_wdata_o, e_wdata);
      check_eq({tag, "_req_stall"}, 32'(mem_stall_o), 32'd1);
      if (i == gnt_wait) begin
        dm_rvalid_i = 1'b0;
        dm_gnt_i    = 1'b1;
      end else begin
        // Stray response while still in REQ must be ignored.
        dm_rvalid_i = 1'b1;
        dm_rdata_i  = 32'hBAD0BAD0;
      end
      step();
    end
    dm_gnt_i = 1'b0;
    check_eq({tag, "_wait_req"}, 32'(dm_req_o), 32'd0);
    check_eq({tag, "_wait_stall"}, 32'(mem_stall_o), 32'd1);
    dm_rvalid_i = 1'b1;
    dm_rdata_i  = rword;
    step();
    dm_rvalid_i = 1'b0;
    dm_rdata_i  = 32'h0;
    check_eq({tag, "_done_stall"}, 32'(mem_stall_o), 32'd0);
    check_eq({tag, "_done_req"}, 32'(dm_req_o), 32'd0);
  endtask

  task automatic finish_txn(input string tag);
    drive(1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    stall_i = 1'b0;
    step();
    check_eq({tag, "_idle_stall"}, 32'(mem_stall_o), 32'd0);
  endtask

  task automatic run_misaligned(input string tag, input logic rd, input logic [2:0] lc,
                                input logic [1:0] sc, input logic [31:0] a);
    step();
    drive(rd, lc, sc, a, 32'h12345678);
    #1;
    check_eq({tag, "_c0_misalign"}, 32'(misalign_o), 32'd1);
    check_eq({tag, "_c0_stall"}, 32'(mem_stall_o), 32'd1);
    check_eq({tag, "_c0_req"}, 32'(dm_req_o), 32'd0);
    step();
    check_eq({tag, "_c1_misalign"}, 32'(misalign_o), 32'd0);
    check_eq({tag, "_c1_stall"}, 32'(mem_stall_o), 32'd0);
    check_eq({tag, "_c1_req"}, 32'(dm_req_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    stall_i     = 1'b0;
    dm_gnt_i    = 1'b0;
    dm_rvalid_i = 1'b0;
    dm_rdata_i  = 32'h0;
    #3;
    check_eq("rst_req", 32'(dm_req_o), 32'd0);
    check_eq("rst_we", 32'(dm_we_o), 32'd0);
    check_eq("rst_addr", dm_addr_o, 32'h0);
    check_eq("rst_wstrb", 32'(dm_wstrb_o), 32'd0);
    check_eq("rst_wdata", dm_wdata_o, 32'h0);
    check_eq("rst_load", load_data_o, 32'h0);
    check_eq("rst_misalign", 32'(misalign_o), 32'd0);
    check_eq("rst_stall", 32'(mem_stall_o), 32'd0);
    #9;
    rst = 1'b0;

    run_txn("lw", 1'b1, 3'b010, 2'b00, 32'h100, 32'h0, 32'hDEADBEEF, 0,
            32'h100, 1'b0, 4'b0000, 32'h0);
    check_eq("lw_load", load_data_o, 32'hDEADBEEF);
    finish_txn("lw");

    run_txn("lb", 1'b1, 3'b000, 2'b00, 32'h103, 32'h0, 32'h80FF1234, 0,
            32'h100, 1'b0, 4'b0000, 32'h0);
    check_eq("lb_load", load_data_o, 32'hFFFFFF80);
    finish_txn("lb");

    run_txn("lh", 1'b1, 3'b001, 2'b00, 32'h102, 32'h0, 32'h80FF1234, 0,
            32'h100, 1'b0, 4'b0000, 32'h0);
    check_eq("lh_load", load_data_o, 32'hFFFF80FF);
    finish_txn("lh");

    run_txn("lbu", 1'b1, 3'b100, 2'b00, 32'h103, 32'h0, 32'h80FF1234, 0,
            32'h100, 1'b0, 4'b0000, 32'h0);
    check_eq("lbu_load", load_data_o, 32'h00000080);
    finish_txn("lbu");

    run_txn("sb", 1'b0, 3'b000, 2'b01, 32'h101, 32'h0000005A, 32'h12345678, 0,
            32'h100, 1'b1, 4'b0010, 32'h5A5A5A5A);
    check_eq("sb_load_kept", load_data_o, 32'h00000080);
    finish_txn("sb");

    run_txn("sh", 1'b0, 3'b000, 2'b10, 32'h202, 32'h0000ABCD, 32'h12345678, 0,
            32'h200, 1'b1, 4'b1100, 32'hABCDABCD);
    check_eq("sh_load_kept", load_data_o, 32'h00000080);
    finish_txn("sh");

    // Store with mem_read_i also set: store wins, gnt withheld three cycles.
    run_txn("sw_hold", 1'b1, 3'b010, 2'b11, 32'h304, 32'hCAFEF00D, 32'h11111111, 3,
            32'h304, 1'b1, 4'b1111, 32'hCAFEF00D);
    check_eq("sw_hold_load_kept", load_data_o, 32'h00000080);
    finish_txn("sw_hold");

    run_misaligned("lh_mis", 1'b1, 3'b001, 2'b00, 32'h305);
    check_eq("lh_mis_load", load_data_o, 32'h0);
    finish_txn("lh_mis");

    run_misaligned("sw_mis", 1'b0, 3'b000, 2'b11, 32'h301);
    finish_txn("sw_mis");

    // stall_i holds DONE with no re-request, even with bus noise.
    run_txn("lw_stall", 1'b1, 3'b010, 2'b00, 32'h500, 32'h0, 32'h0BADF00D, 0,
            32'h500, 1'b0, 4'b0000, 32'h0);
    stall_i     = 1'b1;
    dm_gnt_i    = 1'b1;
    dm_rvalid_i = 1'b1;
    dm_rdata_i  = 32'h77777777;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("done_hold_stall", 32'(mem_stall_o), 32'd0);
      check_eq("done_hold_req", 32'(dm_req_o), 32'd0);
      check_eq("done_hold_load", load_data_o, 32'h0BADF00D);
    end
    dm_gnt_i    = 1'b0;
    dm_rvalid_i = 1'b0;
    finish_txn("lw_stall");

    // Reset while in WAIT; the late response must be dropped.
    step();
    drive(1'b1, 3'b010, 2'b00, 32'h700, 32'h0);
    step();
    dm_gnt_i = 1'b1;
    step();
    dm_gnt_i = 1'b0;
    check_eq("rstw_in_wait_stall", 32'(mem_stall_o), 32'd1);
    rst = 1'b1;
    drive(1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    #1;
    check_eq("rstw_req", 32'(dm_req_o), 32'd0);
    check_eq("rstw_addr", dm_addr_o, 32'h0);
    check_eq("rstw_load", load_data_o, 32'h0);
    check_eq("rstw_stall", 32'(mem_stall_o), 32'd0);
    step();
    rst = 1'b0;
    dm_rvalid_i = 1'b1;
    dm_rdata_i  = 32'hFFFFFFFF;
    step();
    dm_rvalid_i = 1'b0;
    check_eq("late_rvalid_load", load_data_o, 32'h0);
    check_eq("late_rvalid_stall", 32'(mem_stall_o), 32'd0);

    run_txn("lhu", 1'b1, 3'b101, 2'b00, 32'h702, 32'h0, 32'h80FF1234, 0,
            32'h700, 1'b0, 4'b0000, 32'h0);
    check_eq("lhu_load", load_data_o, 32'h000080FF);
    finish_txn("lhu");

    // Reset in REQ drops dm_req_o without waiting for a clock edge.
    step();
    drive(1'b1, 3'b010, 2'b00, 32'h800, 32'h0);
    step();
    check_eq("rstr_req_before", 32'(dm_req_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rstr_req_async", 32'(dm_req_o), 32'd0);
    drive(1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    step();
    check_eq("rstr_idle_stall", 32'(mem_stall_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
